// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
// This is the command front-end for the combinational 8-bit ALU.
// It takes one operation per valid/ready handshake and drives the ALU inputs from registers.
// After SETTLE_CYCLES it captures alu_result and holds it on a valid/ready response port.
//
// Ports:
//   clock, clear_n               system clock; asynchronous active-low reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_a, cmd_b, cmd_opcode     command payload
//   alu_a, alu_b, alu_opcode     registered drive to the ALU
//   alu_result                   combinational ALU output
//   rsp_valid/rsp_ready          response handshake
//   rsp_result, rsp_error        captured result; rsp_error marks an illegal opcode
//   op_count                     count of completed responses, modulo 256
//   rsp_zero                     present only with ALU_ISSUE_ZERO_FLAG_EN; high when the
//                                captured result is zero on a non-error response
//
// Optional feature macro: ALU_ISSUE_ZERO_FLAG_EN
//
// state | meaning
// IDLE  | ready for a command
// DRIVE | ALU inputs held while the result settles
// HOLD  | response presented, waiting for rsp_ready
module alu_issue_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [3:0]  MAX_OPCODE    = 4'b0010
) (
  input  logic       clock,
  input  logic       clear_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic [3:0] cmd_opcode,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_opcode,
  input  logic [7:0] alu_result,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic       rsp_error,
`ifdef ALU_ISSUE_ZERO_FLAG_EN
  output logic       rsp_zero,
`endif
  output logic [7:0] op_count
);

  localparam logic [3:0] LP_CNT_LAST = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  logic [3:0] r_cnt;
  logic [7:0] r_alu_a;
  logic [7:0] r_alu_b;
  logic [3:0] r_alu_opcode;
  logic [7:0] r_rsp_result;
  logic       r_rsp_error;
  logic [7:0] r_op_count;

  logic       w_load;
  logic       w_reject;
  logic       w_capture;
  logic       w_done;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_reject    = 1'b0;
    w_capture   = 1'b0;
    w_done      = 1'b0;
    cmd_ready   = 1'b0;
    rsp_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_opcode > MAX_OPCODE) begin
            w_reject    = 1'b1;
            w_state_nxt = HOLD;
          end else begin
            w_load      = 1'b1;
            w_state_nxt = DRIVE;
          end
        end
      end
      DRIVE: begin
        if (r_cnt == LP_CNT_LAST) begin
          w_capture   = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_cnt        <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_opcode <= '0;
      r_rsp_result <= '0;
      r_rsp_error  <= 1'b0;
      r_op_count   <= '0;
    end else begin
      if (w_load) begin
        r_alu_a      <= cmd_a;
        r_alu_b      <= cmd_b;
        r_alu_opcode <= cmd_opcode;
        r_cnt        <= '0;
      end else if (r_state == DRIVE) begin
        r_cnt <= r_cnt + 4'd1;
      end
      // An illegal opcode leaves the ALU drive untouched and answers with a zero error result.
      if (w_reject) begin
        r_rsp_result <= '0;
        r_rsp_error  <= 1'b1;
      end else if (w_capture) begin
        r_rsp_result <= alu_result;
        r_rsp_error  <= 1'b0;
      end
      if (w_done) begin
        r_op_count <= r_op_count + 8'd1;
      end
    end
  end

`ifdef ALU_ISSUE_ZERO_FLAG_EN
  logic r_rsp_zero;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_rsp_zero <= 1'b0;
    end else if (w_reject) begin
      r_rsp_zero <= 1'b0;
    end else if (w_capture) begin
      r_rsp_zero <= (alu_result == 8'h00);
    end
  end

  assign rsp_zero = r_rsp_zero;
`endif

  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_opcode = r_alu_opcode;
  assign rsp_result = r_rsp_result;
  assign rsp_error  = r_rsp_error;
  assign op_count   = r_op_count;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  localparam int S = 2;

  logic       clock = 1'b0;
  logic       clear_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_a = '0;
  logic [7:0] cmd_b = '0;
  logic [3:0] cmd_opcode = '0;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_opcode;
  logic [7:0] alu_result;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_result;
  logic       rsp_error;
  logic [7:0] op_count;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
  logic       rsp_zero;
`endif

  alu_issue_ctrl #(.SETTLE_CYCLES(S), .MAX_OPCODE(4'b0010)) dut (
    .clock      (clock),
    .clear_n    (clear_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_opcode (cmd_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_error  (rsp_error),
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    .rsp_zero   (rsp_zero),
`endif
    .op_count   (op_count)
  );

  always #5 clock = ~clock;

  // Stand-in for the combinational datapath ALU.
  always_comb begin
    alu_result = 8'h00;
    case (alu_opcode)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = ~alu_a;
      default: alu_result = 8'h00;
    endcase
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] res;
    logic       err;
    int         lat;
    int         acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: each time a response appears, it pops the oldest expectation and compares.
  initial begin : monitor
    bit   seen;
    exp_t e;
    seen = 1'b0;
    forever begin
      @(negedge clock);
      if (!clear_n) begin
        seen = 1'b0;
      end else if (rsp_valid && !seen) begin
        seen = 1'b1;
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_result", 32'(rsp_result), 32'(e.res));
          chk("rsp_error", 32'(rsp_error), 32'(e.err));
          chk("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
`ifdef ALU_ISSUE_ZERO_FLAG_EN
          chk("rsp_zero", 32'(rsp_zero), 32'((e.res == 8'h00) && !e.err));
`endif
        end
      end else if (!rsp_valid) begin
        seen = 1'b0;
      end
    end
  end

  // Call at posedge+1. Returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                      input logic [7:0] eres, input logic eerr, input int lat, input bit track,
                      output int acc, output int stalls);
    exp_t e;
    cmd_a = a; cmd_b = b; cmd_opcode = op; cmd_valid = 1'b1;
    acc = -1; stalls = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      if (cmd_ready) begin
        @(posedge clock); #1;
        acc = cyc;
        break;
      end
      stalls++;
    end
    if (acc < 0) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else if (track) begin
      e.res = eres; e.err = eerr; e.lat = lat; e.acc = acc;
      exp_q.push_back(e);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && !rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("response_timeout", 32'd0, 32'd1);
    @(posedge clock); #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_alu"}, {12'd0, alu_a, alu_b, alu_opcode}, 32'd0);
    chk({tag, "_rsp"}, {22'd0, rsp_valid, rsp_error, rsp_result}, 32'd0);
    chk({tag, "_op_count"}, 32'(op_count), 32'd0);
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    chk({tag, "_rsp_zero"}, 32'(rsp_zero), 32'd0);
`endif
  endtask

  initial begin : stim
    int a1, a2, st, cnt0;
    bit stable;
    logic [7:0] va, vb, er;
    logic [3:0] vop;

    #2;
    chk_reset_vals("reset");
    @(posedge clock); #1;
    clear_n = 1'b1;
    rsp_ready = 1'b1;

    // 16 AND 3 = 0
    send(8'd16, 8'd3, 4'b0000, 8'h00, 1'b0, S, 1'b1, a1, st);
    chk("alu_a_after_accept", 32'(alu_a), 32'd16);
    chk("alu_b_after_accept", 32'(alu_b), 32'd3);
    wait_done();
    chk("op_count_first", 32'(op_count), 32'd1);

    // Back-to-back with cmd_valid held: OR then NOT.
    send(8'd16, 8'd3, 4'b0001, 8'd19, 1'b0, S, 1'b1, a1, st);
    send(8'd16, 8'd3, 4'b0010, 8'hEF, 1'b0, S, 1'b1, a2, st);
    chk("b2b_spacing", 32'(a2 - a1), 32'(S + 2));
    chk("b2b_ready_low_cycles", 32'(st), 32'(S + 1));
    wait_done();

    // Illegal opcode keeps the ALU drive and answers immediately with an error.
    send(8'hAA, 8'h55, 4'b0111, 8'h00, 1'b1, 0, 1'b1, a1, st);
    chk("illegal_alu_opcode_kept", 32'(alu_opcode), 32'h2);
    chk("illegal_alu_a_kept", 32'(alu_a), 32'd16);
    wait_done();
    chk("op_count_after_illegal", 32'(op_count), 32'd4);

    // Backpressure on the response port
    rsp_ready = 1'b0;
    send(8'd16, 8'd3, 4'b0001, 8'd19, 1'b0, S, 1'b1, a1, st);
    stable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (rsp_valid) begin
        stable = 1'b1;
        break;
      end
    end
    chk("bp_rsp_valid_seen", 32'(stable), 32'd1);
    cnt0 = int'(op_count);
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); @(negedge clock);
      if (!(rsp_valid && rsp_result == 8'd19 && !cmd_ready && op_count == 8'(cnt0))) stable = 1'b0;
    end
    chk("bp_hold_stable", 32'(stable), 32'd1);
    @(posedge clock); #1;
    rsp_ready = 1'b1;
    @(negedge clock);
    chk("bp_op_count_before_edge", 32'(op_count), 32'd4);
    @(posedge clock); #1;
    chk("bp_op_count_after_edge", 32'(op_count), 32'd5);
    wait_done();

    // A reset in the middle of DRIVE drops the in-flight command.
    send(8'h0F, 8'hF0, 4'b0001, 8'h00, 1'b0, S, 1'b0, a1, st);
    #2;
    clear_n = 1'b0;
    #1;
    chk_reset_vals("mid_drive_clear");
    @(posedge clock); #1;
    clear_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
    end
    chk("no_rsp_after_clear", 32'(rsp_valid), 32'd0);
    send(8'hF0, 8'h0F, 4'b0001, 8'hFF, 1'b0, S, 1'b1, a1, st);
    wait_done();
    chk("op_count_after_clear", 32'(op_count), 32'd1);

    // Another 255 completions take op_count from 1 around to 0.
    for (int i = 0; i < 255; i++) begin
      va = 8'(i * 7 + 1);
      vb = 8'(i * 13 + 5);
      vop = 4'(i % 4);
      case (vop)
        4'd0: er = va & vb;
        4'd1: er = va | vb;
        4'd2: er = ~va;
        default: er = 8'h00;
      endcase
      send(va, vb, vop, er, (vop == 4'd3), (vop == 4'd3) ? 0 : S, 1'b1, a1, st);
    end
    wait_done();
    chk("op_count_wrap", 32'(op_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
